// File: rtl/mem_ctrl_pkg.sv
// Shared defines for the byte-serial memory controller: bus widths,
// FSM state encoding, transaction owner and the UART/IO address tag.
package mem_ctrl_pkg;

    localparam int InstAddrBus = 32;
    localparam int RegBus      = 32;

    // Address bits [17:16] equal to this tag select the IO (UART) region.
    localparam logic [1:0] IO_ADDR_TAG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller. Arbitrates instruction-fetch (IF) and
// load/store (MM) requests onto an 8-bit synchronous RAM/IO port, one
// byte per cycle, assembling little-endian words for reads.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   io_buffer_full,
    input  logic                   if_req_i,
    input  logic [InstAddrBus-1:0] if_addr_i,
    input  logic                   if_flush_i,
    output logic                   if_done_o,
    output logic [RegBus-1:0]      if_inst_o,
    input  logic                   mm_req_i,
    input  logic                   mm_we_i,
    input  logic [31:0]            mm_addr_i,
    input  logic [1:0]             mm_len_i,
    input  logic [RegBus-1:0]      mm_wdata_i,
    output logic                   mm_done_o,
    output logic [RegBus-1:0]      mm_rdata_o,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout,
    output logic [31:0]            mem_a,
    output logic                   mem_wr
);

    state_t      state_r, state_s;
    owner_t      owner_r, owner_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [31:0] base_r, base_s;
    logic [1:0]  len_r, len_s;
    logic [31:0] wdata_r, wdata_s;
    logic [31:0] buf_r, buf_s;
    logic [1:0]  lane_s;
    logic        finish_s;
    logic        io_stall_s;
    logic        flush_s;

    // The RAM returns data one cycle after the address, so the byte seen at
    // cnt belongs to lane cnt-1 (cnt=4 wraps to lane 3).
    assign lane_s     = cnt_r[1:0] - 2'd1;
    assign io_stall_s = (base_r[17:16] == IO_ADDR_TAG) && io_buffer_full;
    assign flush_s    = (state_r == ST_RD) && (owner_r == OWN_IF) && if_flush_i;

    // Next-state, counter and read-assembly logic.
    always_comb begin
        state_s  = state_r;
        owner_s  = owner_r;
        cnt_s    = cnt_r;
        base_s   = base_r;
        len_s    = len_r;
        wdata_s  = wdata_r;
        buf_s    = buf_r;
        finish_s = 1'b0;
        if (flush_s) begin
            // A flushed fetch is abandoned even while the core is frozen.
            state_s = ST_IDLE;
            cnt_s   = 3'd0;
        end else if (!rdy_in) begin
            state_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_s = 3'd0;
                    if (mm_req_i) begin
                        base_s  = mm_addr_i;
                        len_s   = mm_len_i;
                        wdata_s = mm_wdata_i;
                        owner_s = OWN_MM;
                        buf_s   = 32'd0;
                        state_s = mm_we_i ? ST_WR : ST_RD;
                    end else if (if_req_i && !if_flush_i) begin
                        base_s  = if_addr_i;
                        len_s   = 2'd3;
                        owner_s = OWN_IF;
                        buf_s   = 32'd0;
                        state_s = ST_RD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (cnt_r != 3'd0) begin
                        buf_s[{lane_s, 3'b000} +: 8] = mem_din;
                    end else begin
                        buf_s = buf_r;
                    end
                    if (cnt_r == ({1'b0, len_r} + 3'd1)) begin
                        state_s  = ST_DONE;
                        finish_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end
                ST_WR: begin
                    if (io_stall_s) begin
                        cnt_s = cnt_r;
                    end else if (cnt_r == {1'b0, len_r}) begin
                        state_s = ST_DONE;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                    cnt_s   = 3'd0;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 3'd0;
                end
            endcase
        end
    end

    // Control and assembly registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r <= ST_IDLE;
            owner_r <= OWN_IF;
            cnt_r   <= 3'd0;
            base_r  <= 32'd0;
            len_r   <= 2'd0;
            wdata_r <= 32'd0;
            buf_r   <= 32'd0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            cnt_r   <= cnt_s;
            base_r  <= base_s;
            len_r   <= len_s;
            wdata_r <= wdata_s;
            buf_r   <= buf_s;
        end
    end

    // Result registers: updated only when a read completes, held otherwise.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            if_inst_o  <= 32'd0;
            mm_rdata_o <= 32'd0;
        end else if (finish_s && (owner_r == OWN_MM)) begin
            mm_rdata_o <= buf_s;
        end else if (finish_s) begin
            if_inst_o <= buf_s;
        end else begin
            if_inst_o  <= if_inst_o;
            mm_rdata_o <= mm_rdata_o;
        end
    end

    // Memory port and done pulses decoded from the registered state.
    always_comb begin
        mem_a     = 32'd0;
        mem_dout  = 8'd0;
        mem_wr    = 1'b0;
        if_done_o = (state_r == ST_DONE) && (owner_r == OWN_IF);
        mm_done_o = (state_r == ST_DONE) && (owner_r == OWN_MM);
        case (state_r)
            ST_RD: begin
                // While frozen, re-present the previous address so mem_din
                // holds the byte still owed on the first ready cycle.
                if (!rdy_in && (cnt_r != 3'd0)) begin
                    mem_a = base_r + {29'd0, cnt_r} - 32'd1;
                end else if (cnt_r <= {1'b0, len_r}) begin
                    mem_a = base_r + {29'd0, cnt_r};
                end else begin
                    mem_a = 32'd0;
                end
            end
            ST_WR: begin
                if (cnt_r <= {1'b0, len_r}) begin
                    mem_a    = base_r + {29'd0, cnt_r};
                    mem_dout = wdata_r[{cnt_r[1:0], 3'b000} +: 8];
                    mem_wr   = rdy_in && !io_stall_s;
                end else begin
                    mem_a = 32'd0;
                end
            end
            default: begin
                mem_a = 32'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a synchronous byte RAM model.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, io_buffer_full;
    logic        if_req_i, if_flush_i, if_done_o;
    logic [31:0] if_addr_i, if_inst_o;
    logic        mm_req_i, mm_we_i, mm_done_o;
    logic [31:0] mm_addr_i, mm_wdata_i, mm_rdata_o;
    logic [1:0]  mm_len_i;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  ram [0:4095];
    int          wr_cnt = 0;
    logic [31:0] last_wa = 32'd0;
    logic [7:0]  last_wd = 8'd0;

    int cmp_cnt = 0;
    int err_cnt = 0;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .io_buffer_full(io_buffer_full),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_done_o(if_done_o), .if_inst_o(if_inst_o),
        .mm_req_i(mm_req_i), .mm_we_i(mm_we_i), .mm_addr_i(mm_addr_i),
        .mm_len_i(mm_len_i), .mm_wdata_i(mm_wdata_i),
        .mm_done_o(mm_done_o), .mm_rdata_o(mm_rdata_o),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM: read data one cycle after address; writes are logged.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_a;
            last_wd <= mem_dout;
        end
    end

    task automatic test_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        #1;
        cmp_cnt++; if (if_done_o !== 1'b0) begin err_cnt++; $display("FAIL reset_if_done got %0b want 0", if_done_o); end
        cmp_cnt++; if (mm_done_o !== 1'b0) begin err_cnt++; $display("FAIL reset_mm_done got %0b want 0", mm_done_o); end
        cmp_cnt++; if (if_inst_o !== 32'd0) begin err_cnt++; $display("FAIL reset_if_inst got %h want 0", if_inst_o); end
        cmp_cnt++; if (mm_rdata_o !== 32'd0) begin err_cnt++; $display("FAIL reset_mm_rdata got %h want 0", mm_rdata_o); end
        cmp_cnt++; if ({mem_wr, mem_a, mem_dout} !== 41'd0) begin err_cnt++; $display("FAIL reset_mem_port got wr=%0b a=%h d=%h want 0", mem_wr, mem_a, mem_dout); end
        rst_in = 1'b1;
    endtask

    task automatic test_if_read();
        int lat = 0;
        @(negedge clk_in);
        if_addr_i = 32'h0000_0100; if_req_i = 1'b1;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                cmp_cnt++; if (mem_a !== 32'h100 || mem_wr !== 1'b0) begin err_cnt++; $display("FAIL if_first_addr got a=%h wr=%0b want 100/0", mem_a, mem_wr); end
            end
            if (if_done_o) begin lat = k; if_req_i = 1'b0; end
        end
        cmp_cnt++; if (lat != 6) begin err_cnt++; $display("FAIL if_word_latency got %0d want 6", lat); end
        cmp_cnt++; if (if_inst_o !== 32'h0000_0513) begin err_cnt++; $display("FAIL if_word_data got %h want 00000513", if_inst_o); end
        @(negedge clk_in);
        cmp_cnt++; if (if_done_o !== 1'b0) begin err_cnt++; $display("FAIL if_done_single got %0b want 0", if_done_o); end
    endtask

    task automatic test_priority();
        int mm_at = 0, if_at = 0, mm_n = 0, if_n = 0;
        @(negedge clk_in);
        mm_addr_i = 32'h200; mm_we_i = 1'b0; mm_len_i = 2'd3; mm_req_i = 1'b1;
        if_addr_i = 32'h104; if_req_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                cmp_cnt++; if (mem_a !== 32'h200) begin err_cnt++; $display("FAIL prio_first_addr got %h want 200", mem_a); end
            end
            if (mm_done_o) begin mm_n++; mm_at = k; mm_req_i = 1'b0; end
            if (if_done_o) begin if_n++; if_at = k; if_req_i = 1'b0; end
        end
        cmp_cnt++; if (mm_at != 6 || mm_n != 1) begin err_cnt++; $display("FAIL prio_mm_done got at=%0d n=%0d want 6/1", mm_at, mm_n); end
        cmp_cnt++; if (if_at != 13 || if_n != 1) begin err_cnt++; $display("FAIL prio_if_done got at=%0d n=%0d want 13/1", if_at, if_n); end
        cmp_cnt++; if (mm_rdata_o !== 32'h1234_5678) begin err_cnt++; $display("FAIL prio_mm_data got %h want 12345678", mm_rdata_o); end
        cmp_cnt++; if (if_inst_o !== 32'hDDCC_BBAA) begin err_cnt++; $display("FAIL prio_if_data got %h want ddccbbaa", if_inst_o); end
    endtask

    task automatic test_narrow_read(input logic [31:0] addr, input logic [1:0] len,
                                    input int want_lat, input logic [31:0] want_data);
        int lat = 0;
        @(negedge clk_in);
        mm_addr_i = addr; mm_we_i = 1'b0; mm_len_i = len; mm_req_i = 1'b1;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk_in);
            if (mm_done_o) begin lat = k; mm_req_i = 1'b0; end
        end
        cmp_cnt++; if (lat != want_lat) begin err_cnt++; $display("FAIL narrow_latency len=%0d got %0d want %0d", len, lat, want_lat); end
        cmp_cnt++; if (mm_rdata_o !== want_data) begin err_cnt++; $display("FAIL narrow_data len=%0d got %h want %h", len, mm_rdata_o, want_data); end
    endtask

    task automatic test_word_write();
        int lat = 0;
        int w0 = wr_cnt;
        @(negedge clk_in);
        mm_addr_i = 32'h400; mm_we_i = 1'b1; mm_len_i = 2'd3; mm_wdata_i = 32'h1122_3344; mm_req_i = 1'b1;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                cmp_cnt++; if (mem_wr !== 1'b1 || mem_a !== 32'h400 || mem_dout !== 8'h44) begin err_cnt++; $display("FAIL sw_first_byte got wr=%0b a=%h d=%h want 1/400/44", mem_wr, mem_a, mem_dout); end
            end
            if (mm_done_o) begin lat = k; mm_req_i = 1'b0; end
        end
        cmp_cnt++; if (lat != 5) begin err_cnt++; $display("FAIL sw_latency got %0d want 5", lat); end
        cmp_cnt++; if (wr_cnt - w0 != 4 || last_wa !== 32'h403 || last_wd !== 8'h11) begin err_cnt++; $display("FAIL sw_writes got n=%0d a=%h d=%h want 4/403/11", wr_cnt - w0, last_wa, last_wd); end
    endtask

    task automatic test_io_stall();
        int lat = 0;
        int w0 = wr_cnt;
        @(negedge clk_in);
        mm_addr_i = 32'h0003_0000; mm_we_i = 1'b1; mm_len_i = 2'd0; mm_wdata_i = 32'hFFFF_FF41; mm_req_i = 1'b1;
        io_buffer_full = 1'b1;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk_in);
            if (k == 4) io_buffer_full = 1'b0;
            #1;
            if (k <= 3) begin
                cmp_cnt++; if (mem_wr !== 1'b0 || mem_a !== 32'h0003_0000) begin err_cnt++; $display("FAIL io_stall_cycle%0d got wr=%0b a=%h want 0/30000", k, mem_wr, mem_a); end
            end
            if (k == 4) begin
                cmp_cnt++; if (mem_wr !== 1'b1 || mem_dout !== 8'h41) begin err_cnt++; $display("FAIL io_release got wr=%0b d=%h want 1/41", mem_wr, mem_dout); end
            end
            if (mm_done_o) begin lat = k; mm_req_i = 1'b0; end
        end
        cmp_cnt++; if (lat != 5) begin err_cnt++; $display("FAIL io_latency got %0d want 5", lat); end
        cmp_cnt++; if (wr_cnt - w0 != 1 || last_wa !== 32'h0003_0000 || last_wd !== 8'h41) begin err_cnt++; $display("FAIL io_writes got n=%0d a=%h d=%h want 1/30000/41", wr_cnt - w0, last_wa, last_wd); end
    endtask

    task automatic test_rdy_freeze();
        int lat = 0;
        @(negedge clk_in);
        mm_addr_i = 32'h200; mm_we_i = 1'b0; mm_len_i = 2'd3; mm_req_i = 1'b1;
        for (int k = 1; k <= 15 && lat == 0; k++) begin
            @(negedge clk_in);
            if (k == 3) rdy_in = 1'b0;
            if (k == 5) rdy_in = 1'b1;
            #1;
            if (k == 3 || k == 4) begin
                cmp_cnt++; if (mem_a !== 32'h201 || mem_wr !== 1'b0) begin err_cnt++; $display("FAIL freeze_addr_cycle%0d got a=%h wr=%0b want 201/0", k, mem_a, mem_wr); end
            end
            if (mm_done_o) begin lat = k; mm_req_i = 1'b0; end
        end
        cmp_cnt++; if (lat != 8) begin err_cnt++; $display("FAIL freeze_latency got %0d want 8", lat); end
        cmp_cnt++; if (mm_rdata_o !== 32'h1234_5678) begin err_cnt++; $display("FAIL freeze_data got %h want 12345678", mm_rdata_o); end
    endtask

    task automatic test_flush();
        int n_done = 0;
        @(negedge clk_in);
        if_addr_i = 32'h100; if_req_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            if (k == 3) if_flush_i = 1'b1;
            #1;
            if (k == 4) begin
                cmp_cnt++; if (mem_a !== 32'd0 || mem_wr !== 1'b0) begin err_cnt++; $display("FAIL flush_idle got a=%h wr=%0b want 0/0", mem_a, mem_wr); end
                if_flush_i = 1'b0; if_req_i = 1'b0;
            end
            if (if_done_o) n_done++;
        end
        cmp_cnt++; if (n_done != 0) begin err_cnt++; $display("FAIL flush_no_done got %0d want 0", n_done); end
        cmp_cnt++; if (if_inst_o !== 32'hDDCC_BBAA) begin err_cnt++; $display("FAIL flush_inst_held got %h want ddccbbaa", if_inst_o); end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        int w0 = wr_cnt;
        @(negedge clk_in);
        mm_addr_i = 32'h300; mm_we_i = 1'b1; mm_len_i = 2'd3; mm_wdata_i = 32'hCAFE_BABE; mm_req_i = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        #1;
        cmp_cnt++; if ({mem_wr, mem_a, mem_dout} !== 41'd0) begin err_cnt++; $display("FAIL rstmid_port got wr=%0b a=%h d=%h want 0", mem_wr, mem_a, mem_dout); end
        cmp_cnt++; if ({if_done_o, mm_done_o} !== 2'b00) begin err_cnt++; $display("FAIL rstmid_done got %b want 00", {if_done_o, mm_done_o}); end
        cmp_cnt++; if (if_inst_o !== 32'd0 || mm_rdata_o !== 32'd0) begin err_cnt++; $display("FAIL rstmid_data got %h/%h want 0/0", if_inst_o, mm_rdata_o); end
        cmp_cnt++; if (wr_cnt - w0 != 2) begin err_cnt++; $display("FAIL rstmid_partial_writes got %0d want 2", wr_cnt - w0); end
        rst_in = 1'b1; mm_req_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in);
            if (mm_done_o) n_done++;
        end
        cmp_cnt++; if (n_done != 0) begin err_cnt++; $display("FAIL rstmid_no_done got %0d want 0", n_done); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h104] = 8'hAA; ram[12'h105] = 8'hBB; ram[12'h106] = 8'hCC; ram[12'h107] = 8'hDD;
        ram[12'h200] = 8'h78; ram[12'h201] = 8'h56; ram[12'h202] = 8'h34; ram[12'h203] = 8'h12;
        ram[12'h208] = 8'h9C;
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
        if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = 32'd0;
        mm_req_i = 1'b0; mm_we_i = 1'b0; mm_addr_i = 32'd0; mm_len_i = 2'd0; mm_wdata_i = 32'd0;

        test_reset();
        test_if_read();
        test_priority();
        test_narrow_read(32'h208, 2'd0, 3, 32'h0000_009C);
        test_narrow_read(32'h200, 2'd1, 4, 32'h0000_5678);
        test_rdy_freeze();
        test_flush();
        test_word_write();
        test_io_stall();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous active-low reset, named clk_in and rst_in.
REQ-002 clk_in  in  1  system clock; all state updates on rising edge.
REQ-003 rst_in  in  1  synchronous active-low reset; acts only at a rising edge of clk_in.
REQ-004 rdy_in  in  1  high = run, low = freeze.
REQ-005 io_buffer_full  in  1  high = UART buffer full.
REQ-006 if_req_i  in  1, if_addr_i  in  32  instruction fetch request, held high until if_done_o.
REQ-007 if_flush_i  in  1  cancels any fetch, pending or in flight.
REQ-008 if_done_o  out  1, if_inst_o  out  32  fetch done pulse and little-endian word.
REQ-009 mm_req_i  in  1, mm_we_i  in  1, mm_addr_i  in  32, mm_len_i  in  2 (bytes-1: 0, 1 or 3), mm_wdata_i  in  32  load/store request, held until mm_done_o.
REQ-010 mm_done_o  out  1, mm_rdata_o  out  32  load/store done pulse and zero-extended read data.
REQ-011 mem_din  in  8, mem_dout  out  8, mem_a  out  32, mem_wr  out  1 (1 = write)  byte-wide RAM/IO port.

Function
REQ-012 SHALL implement FSM states IDLE, RD, WR and DONE, with a byte counter cnt (3 bits) and latched base, len, wdata and owner (IF/MM).
REQ-013 IDLE: if mm_req_i is high, SHALL latch the MM request and go to RD or WR according to mm_we_i; else if if_req_i is high and if_flush_i is low, SHALL latch IF with len=3 and go to RD; cnt<=0.
REQ-014 The MM request SHALL win over the IF request when both are high in the same cycle.
REQ-015 RD cycle with cnt<=len: SHALL drive mem_a=base+cnt and mem_wr=0.
REQ-016 RD cycle with cnt>=1: SHALL capture mem_din into byte lane cnt-1.
REQ-017 RD: cnt SHALL increment each cycle, and the FSM SHALL go to DONE after the capture at cnt=len+1.
REQ-018 WR cycle with cnt<=len: SHALL drive mem_a=base+cnt, mem_dout=wdata byte cnt and mem_wr=1; after cnt=len the FSM SHALL go to DONE.
REQ-019 IO stall: in WR, when base[17:16]==2'b11 and io_buffer_full=1, mem_wr SHALL be 0 and cnt SHALL hold.
REQ-020 DONE: SHALL last exactly one cycle with the owner's done output high and the other done output low, then go to IDLE.
REQ-021 Requesters SHALL drop their request in the cycle after done; this makes IDLE the one-cycle gap between transactions.
REQ-022 Latency, counted from the IDLE sampling cycle T: word read done at T+6, byte read done at T+3, word write done at T+5, byte write done at T+2.
REQ-023 if_inst_o and mm_rdata_o SHALL hold their values from the last completed transaction until the next done; unused upper bytes SHALL read 0.
REQ-024 if_flush_i high while owner=IF in RD: the FSM SHALL go to IDLE next cycle with no if_done_o; flush SHALL NOT affect MM transactions.
REQ-025 rdy_in low: state, cnt and captured data SHALL freeze, and mem_wr SHALL be 0.
REQ-026 rdy_in low in RD with cnt>=1: mem_a SHALL be base+cnt-1, so that mem_din is valid on the first ready cycle.
REQ-027 Address arithmetic SHALL be 32-bit modulo 2^32 (wrap-around allowed, no fault).
REQ-028 Outside RD/WR, mem_wr SHALL be 0, mem_a SHALL be 0 and mem_dout SHALL be 0.

Reset
REQ-029 rst_in=0 at an edge SHALL give state=IDLE, cnt=0, if_done_o=0, mm_done_o=0, if_inst_o=0, mm_rdata_o=0, mem_wr=0, mem_a=0 and mem_dout=0.
REQ-030 Reset mid-transaction SHALL abort it with no done pulse; partial writes already issued are not undone.
REQ-031 Reset SHALL take priority over rdy_in.

Structure
REQ-032 FSM state encoding and the IO address constant (2'b11 at bits 17:16) SHALL live in the shared defines package, alongside InstAddrBus/RegBus.
REQ-033 SHALL be a single module with no sub-module; the byte-lane insert/extract logic is inline.

Verification
REQ-034 IF word read at 0x0000_0100, RAM bytes 13,05,00,00 -> if_done_o at T+6, if_inst_o=0x0000_0513.
REQ-035 mm_req (lw, 0x200) and if_req (0x104) in the same cycle -> MM served first (mm_done_o), then IF; exactly one done pulse each.
REQ-036 sb 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write, mm_done_o at T+5.
REQ-037 rdy_in low for 2 cycles during the word read at cnt=2 -> mem_a=base+1 while frozen, final data correct, done 2 cycles late.
REQ-038 if_flush_i at cnt=2 of an IF read -> no if_done_o, IDLE next cycle, if_inst_o unchanged.
REQ-039 rst_in low during sw at cnt=1 -> all outputs 0 next cycle and no mm_done_o.
